// File: rtl/demux12_2b.sv
// demux12_2b: 1:2 valid-stream demultiplexer with a small FIFO per lane.
// Ports: clk/reset, in/in_valid/select -> in_ready, pop0/pop1 -> out0/out1,
//        out0_valid/out1_valid, count0/count1 occupancy, sticky drop_err.

module demux12_2b_lane #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop & valid;
  assign head   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally; full/empty come from count alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module demux12_2b #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             select,
  input  logic             pop0,
  input  logic             pop1,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out1,
  output logic             out1_valid,
  output logic [CW-1:0]    count0,
  output logic [CW-1:0]    count1,
  output logic             drop_err
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic accept;
  logic push0;
  logic push1;

  // Readiness looks at registered counts only, never same-cycle pops.
  assign in_ready = select ? (count1 != FULL) : (count0 != FULL);
  assign accept   = in_valid & in_ready;
  assign push0    = accept & ~select;
  assign push1    = accept & select;

  demux12_2b_lane #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)
  ) u_lane0 (
    .clk   (clk),
    .reset (reset),
    .push  (push0),
    .pop   (pop0),
    .wdata (in),
    .head  (out0),
    .valid (out0_valid),
    .count (count0)
  );

  demux12_2b_lane #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)
  ) u_lane1 (
    .clk   (clk),
    .reset (reset),
    .push  (push1),
    .pop   (pop1),
    .wdata (in),
    .head  (out1),
    .valid (out1_valid),
    .count (count1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   drop_err <= 1'b0;
    else if (in_valid & ~in_ready) drop_err <= 1'b1;
  end

endmodule

// File: tb/tb_demux12_2b.sv
// tb_demux12_2b: directed stimulus for demux12_2b with a per-lane
// expected-word queue and a clock-driven monitor comparing lane outputs.

module tb_demux12_2b;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] in;
  logic       in_valid;
  logic       select;
  logic       pop0;
  logic       pop1;
  logic       in_ready;
  logic [1:0] out0;
  logic       out0_valid;
  logic [1:0] out1;
  logic       out1_valid;
  logic [2:0] count0;
  logic [2:0] count1;
  logic       drop_err;

  int checks = 0;
  int errors = 0;

  logic [1:0] q0 [$];
  logic [1:0] q1 [$];
  bit         exp_drop = 0;

  always #5 clk = ~clk;

  demux12_2b dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .in_valid   (in_valid),
    .select     (select),
    .pop0       (pop0),
    .pop1       (pop1),
    .in_ready   (in_ready),
    .out0       (out0),
    .out0_valid (out0_valid),
    .out1       (out1),
    .out1_valid (out1_valid),
    .count0     (count0),
    .count1     (count1),
    .drop_err   (drop_err)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Consumer side: a pop of a non-empty lane retires the expected head.
  always @(posedge clk) begin
    if (!reset) begin
      if (pop0 && q0.size() != 0) void'(q0.pop_front());
      if (pop1 && q1.size() != 0) void'(q1.pop_front());
    end
  end

  // Monitor: lane outputs versus the scoreboard, away from the edge.
  always @(negedge clk) begin
    logic [1:0] h0;
    logic [1:0] h1;
    h0 = (q0.size() != 0) ? q0[0] : 2'b00;
    h1 = (q1.size() != 0) ? q1[0] : 2'b00;
    chk("mon_out0_valid", out0_valid, q0.size() != 0);
    chk("mon_out0", out0, h0);
    chk("mon_count0", count0, q0.size());
    chk("mon_out1_valid", out1_valid, q1.size() != 0);
    chk("mon_out1", out1, h1);
    chk("mon_count1", count1, q1.size());
    chk("mon_drop_err", drop_err, exp_drop);
  end

  task automatic step(input bit v, input bit s, input logic [1:0] d,
                      input bit p0, input bit p1);
    bit rdy;
    in_valid = v;
    select   = s;
    in       = d;
    pop0     = p0;
    pop1     = p1;
    #1;
    rdy = ((s ? q1.size() : q0.size()) != 4);
    chk("in_ready", in_ready, rdy);
    @(posedge clk);
    #1;
    if (v) begin
      if (rdy) begin
        if (s) q1.push_back(d);
        else   q0.push_back(d);
      end else begin
        exp_drop = 1;
      end
    end
    in_valid = 0;
    pop0     = 0;
    pop1     = 0;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    q0.delete();
    q1.delete();
    exp_drop = 0;
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 0;
    #1;
  endtask

  initial begin
    reset    = 1;
    in       = 2'b00;
    in_valid = 0;
    select   = 0;
    pop0     = 0;
    pop1     = 0;

    // 1: reset and idle
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_out0", out0, 0);
    chk("rst_out1", out1, 0);
    chk("rst_count0", count0, 0);
    chk("rst_count1", count1, 0);
    chk("rst_drop", drop_err, 0);
    do_reset();
    step(0, 0, 2'b00, 0, 0);
    chk("idle_in_ready", in_ready, 1);

    // 2: basic steering
    step(1, 0, 2'b01, 0, 0);
    step(1, 0, 2'b10, 0, 0);
    step(1, 1, 2'b11, 0, 0);
    chk("t2_count0", count0, 2);
    chk("t2_count1", count1, 1);
    chk("t2_out0", out0, 2'b01);
    chk("t2_out1", out1, 2'b11);
    step(0, 0, 2'b00, 1, 0);
    chk("t2_pop_out0", out0, 2'b10);
    chk("t2_pop_count0", count0, 1);

    // 3: full lane refuses, other lane still accepts
    do_reset();
    step(1, 0, 2'b00, 0, 0);
    step(1, 0, 2'b01, 0, 0);
    step(1, 0, 2'b10, 0, 0);
    step(1, 0, 2'b11, 0, 0);
    chk("t3_count0", count0, 4);
    chk("t3_ready_full", in_ready, 0);
    step(1, 0, 2'b01, 0, 0);
    chk("t3_drop", drop_err, 1);
    chk("t3_count0_after", count0, 4);
    step(1, 1, 2'b10, 0, 0);
    chk("t3_count1", count1, 1);
    chk("t3_out1", out1, 2'b10);
    chk("t3_drop_sticky", drop_err, 1);

    // 4: push+pop on the same lane through pointer wrap
    do_reset();
    step(1, 0, 2'b11, 0, 0);
    step(1, 0, 2'b10, 0, 0);
    for (int i = 0; i < 8; i++) begin
      logic [1:0] w;
      w = 2'(i);
      step(1, 0, w, 1, 0);
      chk("t4_count0", count0, 2);
    end
    chk("t4_out0", out0, 2'b10);
    step(0, 0, 2'b00, 1, 0);
    chk("t4_out0_next", out0, 2'b11);

    // 5: pop on empty lane, cross-lane push/pop
    do_reset();
    step(0, 0, 2'b00, 0, 1);
    chk("t5_empty_count1", count1, 0);
    chk("t5_empty_drop", drop_err, 0);
    step(1, 1, 2'b01, 0, 0);
    step(1, 0, 2'b11, 0, 1);
    chk("t5_count0", count0, 1);
    chk("t5_count1", count1, 0);
    chk("t5_out0", out0, 2'b11);

    // 6: asynchronous reset mid-stream
    do_reset();
    step(1, 1, 2'b01, 0, 0);
    step(1, 1, 2'b10, 0, 0);
    step(1, 1, 2'b11, 0, 0);
    step(1, 0, 2'b10, 0, 0);
    step(1, 0, 2'b01, 0, 0);
    chk("t6_pre_count1", count1, 3);
    chk("t6_pre_count0", count0, 2);
    #2;
    reset = 1;
    q0.delete();
    q1.delete();
    exp_drop = 0;
    #1;
    chk("t6_async_count0", count0, 0);
    chk("t6_async_count1", count1, 0);
    chk("t6_async_v0", out0_valid, 0);
    chk("t6_async_v1", out1_valid, 0);
    chk("t6_async_out1", out1, 0);
    chk("t6_async_drop", drop_err, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 0;
    #1;
    step(1, 0, 2'b01, 0, 0);
    chk("t6_first_v0", out0_valid, 1);
    chk("t6_first_out0", out0, 2'b01);
    chk("t6_first_count0", count0, 1);

    step(0, 0, 2'b00, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, limit 100000 ns");
    $fatal(1);
  end

endmodule

// File: doc/demux12_2b.md
Name: demux12_2b

Overview:
- 1:2 demultiplexer with valid: the receive-side counterpart of the 2:1 two-bit valid mux.
- Takes one 2-bit valid stream and steers each accepted word, by select, into one of two output lanes.
- Each lane has a small FIFO so consumers can drain at their own pace.
- Sits downstream of the mux pair so a mux→demux loopback can be checked end to end.

Parameters:
WIDTH  2  data width of in/out words
DEPTH  4  entries per lane FIFO; power of two, ≥2
CW     3  occupancy counter width, clog2(DEPTH)+1

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in  input  WIDTH  input data word
in_valid  input  1  in carries a word this cycle
select  input  1  destination lane for current word: 0→lane0, 1→lane1
pop0  input  1  lane0 consumer takes head word
pop1  input  1  lane1 consumer takes head word
in_ready  output  1  selected lane can accept (combinational)
out0  output  WIDTH  lane0 head word
out0_valid  output  1  lane0 non-empty
out1  output  WIDTH  lane1 head word
out1_valid  output  1  lane1 non-empty
count0  output  CW  lane0 occupancy, 0..DEPTH
count1  output  CW  lane1 occupancy, 0..DEPTH
drop_err  output  1  sticky: a valid word was refused

Behaviour:
- Reset (async, while reset=1):
  - all pointers and counts = 0; out0/out1 = 0; outN_valid = 0; drop_err = 0.
  - in_ready is derived from counts, so in_ready = 1 while in reset and after release.
- in_ready = (select ? count1 : count0) != DEPTH. Combinational from select and registered counts only; no bypass from same-cycle pops.
- Push: in_valid & in_ready at a rising edge writes in into lane[select] at its write pointer; write pointer increments modulo DEPTH.
- Refuse: in_valid & !in_ready:
  - word discarded, no state change in either lane.
  - drop_err set at that edge; stays 1 until reset.
- Pop: popN & outN_valid at an edge advances lane N read pointer modulo DEPTH.
  - popN while empty is ignored: no pointer or count change, no error.
- Count per lane:
  - push only: +1.
  - pop only: −1.
  - push and pop same lane, same edge: unchanged, both pointers advance.
  - Full lane cannot push (in_ready=0), so push+pop on a full lane never occurs.
- Lanes are independent: a push to lane0 and a pop on lane1 in the same cycle both complete.
- Outputs:
  - outN_valid = (countN != 0).
  - outN = memory[rd_ptrN] when valid, else 0.
  - Both are derived from registered state only.
- Latency:
  - word pushed at edge k is visible on outN with outN_valid=1 after edge k (1 cycle, in→out).
  - after a pop at edge k, the next word or empty status is visible after edge k.
- Ordering: strict FIFO per lane; no reordering across lanes; select sampled per word.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally; full/empty are resolved by count, not pointer compare.
- Reset mid-operation: asserting reset at any time flushes both lanes immediately (async). Words in flight are lost; drop_err clears.
- X-safety: select and in are ignored when in_valid=0.

Test Plan:
1. Reset then idle → in_ready=1, out0_valid=out1_valid=0, out0=out1=0, count0=count1=0, drop_err=0.
2. Push 2'b01, 2'b10 with select=0, then 2'b11 with select=1 → after 3rd edge count0=2, count1=1, out0=01, out1=11; pop0 once → out0=10, count0=1.
3. Push 4 words (00,01,10,11) to lane0, no pops → count0=4, in_ready=0 while select=0. 5th push 2'b01 → refused, drop_err=1 sticky. Switch select=1 → in_ready=1, push to lane1 accepted.
4. Lane0 at count 2; same cycle push to lane0 and pop0 → count0 stays 2, FIFO order preserved across 8 consecutive push+pop cycles through pointer wrap.
5. pop1 with lane1 empty → no change, count1=0, drop_err unchanged. Push lane0 and pop1 in the same cycle with lane1 non-empty → both take effect.
6. Fill lane1 to 3 and lane0 to 2, assert reset for 1 cycle mid-stream → outputs clear immediately, counts 0, drop_err 0. After release, first push appears after 1 edge.
